cs_microsequencer: RTL

- Control-store sequencer for the ARC micro-datapath. It computes the next control-store address and drives it to the asynchronous-read control-store ROM.
- Latches the returned word into the Microinstruction Register (MIR), one microinstruction per clock.
- MIR fields A/B/C are the MIR-field inputs of the register-select muxes; the remaining fields drive AMUX/BMUX/CMUX, ALU, memory RD/WR and branching.
- Stalls on memory handshake.

---
 rtl/cs_microsequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/cs_microsequencer.sv
// Control-store sequencer: next-address selection, async-ROM addressing, MIR latch, memory stall.
// Optional CS_SEQ_TRACE_EN adds retired-microinstruction and stall-cycle counters.
module cs_microsequencer #(
   parameter int DATAWIDTH_CS_ADDR = 11,
   parameter int DATAWIDTH_MIR     = 41,
   parameter int DATAWIDTH_IR      = 32
) (
   input  logic                         CS_SEQ_CLOCK_50,
   input  logic                         CS_SEQ_RESET_InLow,
   output logic [DATAWIDTH_CS_ADDR-1:0] CS_SEQ_CS_ADDR_OUT,
   input  logic [DATAWIDTH_MIR-1:0]     CS_SEQ_CS_DATA_IN,
   input  logic [DATAWIDTH_IR-1:0]      CS_SEQ_IR_IN,
   input  logic [3:0]                   CS_SEQ_PSR_NZVC_IN,
   input  logic                         CS_SEQ_MEM_READY_IN,
   output logic [DATAWIDTH_MIR-1:0]     CS_SEQ_MIR_OUT,
   output logic [5:0]                   CS_SEQ_A_OUT,
   output logic [5:0]                   CS_SEQ_B_OUT,
   output logic [5:0]                   CS_SEQ_C_OUT,
`ifdef CS_SEQ_TRACE_EN
   output logic [15:0]                  CS_SEQ_UCOUNT_OUT,
   output logic [15:0]                  CS_SEQ_STALLCOUNT_OUT,
`endif
   output logic                         CS_SEQ_ADVANCE_OUT,
   output logic                         CS_SEQ_STALL_OUT
);

   typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

   state_t                       state_q;
   logic [DATAWIDTH_CS_ADDR-1:0] csar_q;
   logic [DATAWIDTH_MIR-1:0]     mir_q;

   logic [DATAWIDTH_CS_ADDR-1:0] csar_inc;
   logic [DATAWIDTH_CS_ADDR-1:0] jaddr;
   logic [DATAWIDTH_CS_ADDR-1:0] next_addr_d;
   logic [2:0]                   cond;
   logic                         mem_acc;
   logic                         stalled;
   logic                         advance;
   logic                         n_flag, z_flag, v_flag, c_flag;
   logic                         ir_unused;

   assign {n_flag, z_flag, v_flag, c_flag} = CS_SEQ_PSR_NZVC_IN;
   assign cond     = mir_q[13:11];
   assign jaddr    = mir_q[DATAWIDTH_CS_ADDR-1:0];
   assign csar_inc = csar_q + 1'b1;
   assign mem_acc  = mir_q[19] | mir_q[18];
   assign ir_unused = ^{CS_SEQ_IR_IN[29:25], CS_SEQ_IR_IN[18:14], CS_SEQ_IR_IN[12:0]};

   always_comb begin
      next_addr_d = csar_inc;
      case (cond)
         3'b000: next_addr_d = csar_inc;
         3'b001: next_addr_d = n_flag ? jaddr : csar_inc;
         3'b010: next_addr_d = z_flag ? jaddr : csar_inc;
         3'b011: next_addr_d = v_flag ? jaddr : csar_inc;
         3'b100: next_addr_d = c_flag ? jaddr : csar_inc;
         3'b101: next_addr_d = CS_SEQ_IR_IN[13] ? jaddr : csar_inc;
         3'b110: next_addr_d = jaddr;
         default: next_addr_d = {1'b1, CS_SEQ_IR_IN[31:30], CS_SEQ_IR_IN[24:19], 2'b00};
      endcase
   end

   // The stall is decided in the same cycle the memory word sits in MIR, so a
   // RD/WR that finds MEM_READY already high retires without a wait cycle.
   assign stalled = (state_q != IDLE) && mem_acc && !CS_SEQ_MEM_READY_IN;
   assign advance = (state_q != IDLE) && !stalled;

   always_comb begin
      CS_SEQ_CS_ADDR_OUT = '0;
      if (state_q != IDLE) begin
         CS_SEQ_CS_ADDR_OUT = stalled ? csar_q : next_addr_d;
      end
   end

   always_ff @(posedge CS_SEQ_CLOCK_50 or negedge CS_SEQ_RESET_InLow) begin
      if (!CS_SEQ_RESET_InLow) begin
         state_q <= IDLE;
         csar_q  <= '0;
         mir_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               mir_q   <= CS_SEQ_CS_DATA_IN;
               csar_q  <= '0;
               state_q <= RUN;
            end
            RUN, MEM_WAIT: begin
               if (stalled) begin
                  state_q <= MEM_WAIT;
               end else begin
                  mir_q   <= CS_SEQ_CS_DATA_IN;
                  csar_q  <= next_addr_d;
                  state_q <= RUN;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef CS_SEQ_TRACE_EN
   logic [15:0] ucount_q;
   logic [15:0] stallcount_q;

   always_ff @(posedge CS_SEQ_CLOCK_50 or negedge CS_SEQ_RESET_InLow) begin
      if (!CS_SEQ_RESET_InLow) begin
         ucount_q     <= '0;
         stallcount_q <= '0;
      end else begin
         if (advance) ucount_q <= ucount_q + 16'd1;
         if (stalled) stallcount_q <= stallcount_q + 16'd1;
      end
   end

   assign CS_SEQ_UCOUNT_OUT     = ucount_q;
   assign CS_SEQ_STALLCOUNT_OUT = stallcount_q;
`endif

   assign CS_SEQ_MIR_OUT     = mir_q;
   assign CS_SEQ_A_OUT       = mir_q[40:35];
   assign CS_SEQ_B_OUT       = mir_q[33:28];
   assign CS_SEQ_C_OUT       = mir_q[26:21];
   assign CS_SEQ_ADVANCE_OUT = advance;
   assign CS_SEQ_STALL_OUT   = stalled;

endmodule
